// File: rtl/tt_sweep.sv
// Truth-table sweep sequencer: drives every input vector for HOLD cycles,
// captures the DUT response at the end of each window and scores it against EXPECT.
module tt_sweep #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 2,
  parameter int HOLD  = 10,
  parameter logic [N_OUT*(2**N_IN)-1:0] EXPECT = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [N_IN-1:0]            vec,
  output logic                       vec_valid,
  input  logic [N_OUT-1:0]           resp,
  output logic                       sample,
  output logic [N_OUT*(2**N_IN)-1:0] resp_log,
  output logic [N_IN:0]              fail_cnt,
  output logic                       busy,
  output logic                       done,
  output logic                       pass
);

  localparam int NV = 2 ** N_IN;
  localparam int LW = N_OUT * NV;
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(HOLD - 1);
  localparam logic [N_IN:0]   FAIL_MAX = (N_IN + 1)'(NV);
  localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [N_IN-1:0] vec_reg, vec_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [LW-1:0]   log_reg, log_next;
  logic [N_IN:0]   fail_reg, fail_next;
  logic            sample_int;
  logic [N_OUT-1:0] exp_slice;

  assign sample_int = (state_reg == DRIVE) && (cnt_reg == CNT_LAST);
  assign exp_slice  = EXPECT[int'(vec_reg)*N_OUT +: N_OUT];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      vec_reg   <= '0;
      cnt_reg   <= '0;
      log_reg   <= '0;
      fail_reg  <= '0;
    end else begin
      state_reg <= state_next;
      vec_reg   <= vec_next;
      cnt_reg   <= cnt_next;
      log_reg   <= log_next;
      fail_reg  <= fail_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    vec_next   = vec_reg;
    cnt_next   = cnt_reg;
    log_next   = log_reg;
    fail_next  = fail_reg;
    case (state_reg)
      IDLE: begin
        vec_next = '0;
        cnt_next = '0;
        if (start) begin
          state_next = DRIVE;
          log_next   = '0;
          fail_next  = '0;
        end
      end
      DRIVE: begin
        if (sample_int) begin
          log_next[int'(vec_reg)*N_OUT +: N_OUT] = resp;
          if ((resp != exp_slice) && (fail_reg != FAIL_MAX))
            fail_next = fail_reg + 1'b1;
          cnt_next = '0;
          // The terminal vector ends the sweep rather than wrapping to 0.
          if (vec_reg == VEC_LAST)
            state_next = DONE;
          else
            vec_next = vec_reg + 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        vec_next   = '0;
      end
      default: begin
        state_next = IDLE;
        vec_next   = '0;
        cnt_next   = '0;
      end
    endcase
  end

  assign vec       = vec_reg;
  assign vec_valid = (state_reg == DRIVE);
  assign busy      = (state_reg == DRIVE);
  assign sample    = sample_int;
  assign resp_log  = log_reg;
  assign fail_cnt  = fail_reg;
  assign done      = (state_reg == DONE);
  assign pass      = (state_reg == DONE) && (fail_reg == '0);

endmodule
